// File: rtl/vx_warp_select.sv
`default_nettype none
// ============================================================================
// Module      : vx_warp_select
// Description : Warp-selection engine with fixed-priority or round-robin issue,
//               per-warp stall / local-barrier tracking and a deadlock flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_warp_select #(
    parameter int NUM_WARPS     = 8,
    parameter int NUM_BARRIERS  = 4,
    parameter int POLICY        = 1,
    parameter int STALL_TIMEOUT = 100000,
    parameter int NW_WIDTH      = $clog2(NUM_WARPS),
    parameter int NB_WIDTH      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] active_mask,
    input  logic                 unstall_valid,
    input  logic [NW_WIDTH-1:0]  unstall_wid,
    input  logic                 bar_valid,
    input  logic [NW_WIDTH-1:0]  bar_wid,
    input  logic [NB_WIDTH-1:0]  bar_id,
    input  logic [NW_WIDTH-1:0]  bar_size_m1,
    output logic                 sched_valid,
    output logic [NW_WIDTH-1:0]  sched_wid,
    input  logic                 sched_ready,
    output logic [NUM_WARPS-1:0] stalled_mask,
    output logic [NUM_WARPS-1:0] barrier_mask,
    output logic                 timeout,
    output logic                 busy
);

    logic [NUM_WARPS-1:0] stalled_q, stalled_d;
    logic [NUM_WARPS-1:0] bmask_q, bmask_d;
    logic [NUM_WARPS-1:0] barrier_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] barrier_d [NUM_BARRIERS];
    logic                 valid_q, valid_d;
    logic [NW_WIDTH-1:0]  wid_q, wid_d;
    logic [NW_WIDTH-1:0]  rr_q, rr_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_WARPS-1:0] ready;
    logic [NW_WIDTH-1:0]  base, idx, sel_wid;
    logic                 sel_found, load, idle;
    logic [NUM_WARPS-1:0] bar_sel, bar_others;
    logic [NW_WIDTH:0]    bar_cnt;
    logic                 bar_release;

    assign ready = active_mask & ~stalled_q & ~bmask_q;
    assign load  = (!valid_q || sched_ready) && sel_found;

    // Descending scan so the smallest offset from the base wins.
    always_comb begin
        sel_found = 1'b0;
        sel_wid   = '0;
        idx       = '0;
        base      = (POLICY != 0) ? rr_q : '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            idx = base + NW_WIDTH'(i);
            if (ready[idx]) begin
                sel_found = 1'b1;
                sel_wid   = idx;
            end
        end
    end

    always_comb begin
        bar_sel = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (bar_id == NB_WIDTH'(b)) bar_sel = barrier_q[b];
        end
        bar_others = bar_sel & ~(NUM_WARPS'(1) << bar_wid);
        bar_cnt    = '0;
        for (int j = 0; j < NUM_WARPS; j++) begin
            bar_cnt = bar_cnt + (NW_WIDTH + 1)'(bar_others[j]);
        end
        bar_release = (bar_cnt == {1'b0, bar_size_m1});
        bmask_d     = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            barrier_d[b] = barrier_q[b];
            if (bar_valid && bar_id == NB_WIDTH'(b)) begin
                if (bar_release) barrier_d[b] = '0;
                else             barrier_d[b][bar_wid] = 1'b1;
            end
            bmask_d = bmask_d | barrier_d[b];
        end
    end

    // The load-set is applied last so it overrides every clear of the same bit.
    always_comb begin
        stalled_d = stalled_q;
        if (unstall_valid) stalled_d[unstall_wid] = 1'b0;
        if (bar_valid)     stalled_d[bar_wid]     = 1'b0;
        stalled_d = stalled_d & active_mask;
        if (load)          stalled_d[sel_wid]     = 1'b1;
    end

    always_comb begin
        valid_d = valid_q;
        wid_d   = wid_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = 1'b1;
            wid_d   = sel_wid;
            rr_d    = sel_wid + NW_WIDTH'(1);
        end else if (sched_ready) begin
            valid_d = 1'b0;
        end
    end

    assign idle      = (|active_mask) && !(|ready) && !valid_q;
    assign cnt_d     = idle ? cnt_q + 32'd1 : 32'd0;
    assign timeout_d = timeout_q || (idle && cnt_d >= 32'(STALL_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stalled_q <= '0;
            bmask_q   <= '0;
            valid_q   <= 1'b0;
            wid_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            for (int b = 0; b < NUM_BARRIERS; b++) barrier_q[b] <= '0;
        end else begin
            stalled_q <= stalled_d;
            bmask_q   <= bmask_d;
            valid_q   <= valid_d;
            wid_q     <= wid_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            for (int b = 0; b < NUM_BARRIERS; b++) barrier_q[b] <= barrier_d[b];
        end
    end

    assign sched_valid  = valid_q;
    assign sched_wid    = wid_q;
    assign stalled_mask = stalled_q;
    assign barrier_mask = bmask_q;
    assign timeout      = timeout_q;
    assign busy         = (|active_mask) || valid_q;

endmodule
`default_nettype wire
